// File: rtl/palette_pixel_pipe.sv
// -----------------------------------------------------------------------------
// palette_pixel_pipe
//   Pipelined indexed-colour pixel renderer for the VGA output path.
//   Stage A turns (hcount, vcount) into a bitmap read address. The colour index
//   comes back from an external synchronous memory MEM_LATENCY cycles later. It
//   is mapped through a run-time writable palette in stage C. Display enable,
//   syncs and the "inside image" flag travel alongside in a delay line. This
//   keeps vga_r/g/b aligned with the timing signals, MEM_LATENCY+2 cycles
//   after the inputs.
//
// Ports
//   vga_clk                     pixel clock, all state on rising edge
//   reset                       asynchronous active-high reset
//   hcount, vcount              current pixel coordinates
//   de_in, hsync_in, vsync_in   timing generator outputs
//   mem_addr                    registered bitmap read address
//   mem_rdata                   colour index, MEM_LATENCY cycles after mem_addr
//   pal_we/pal_waddr/pal_wdata  palette write request (held until accepted)
//   pal_ready                   write accepted on an edge with pal_we && pal_ready
//   vga_r, vga_g, vga_b         registered colour channels
//   de_out, hsync_out, vsync_out delayed copies of the timing inputs
// -----------------------------------------------------------------------------
module palette_pixel_pipe #(
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          COLOR_DEPTH   = 8,
  parameter int          BPP           = 2,
  parameter int          IMG_WIDTH     = 320,
  parameter int          IMG_HEIGHT    = 240,
  parameter int          X0            = 0,
  parameter int          Y0            = 0,
  parameter int          SCALE_SHIFT   = 1,
  parameter int          MEM_LATENCY   = 1,
  parameter int          SAFE_WRITE    = 1,
  parameter logic [23:0] BORDER_COLOR  = 24'h000000,
  parameter int          ADDR_W        = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     de_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [BPP-1:0]           mem_rdata,
  input  logic                     pal_we,
  input  logic [BPP-1:0]           pal_waddr,
  input  logic [3*COLOR_DEPTH-1:0] pal_wdata,
  output logic                     pal_ready,
  output logic [COLOR_DEPTH-1:0]   vga_r,
  output logic [COLOR_DEPTH-1:0]   vga_g,
  output logic [COLOR_DEPTH-1:0]   vga_b,
  output logic                     de_out,
  output logic                     hsync_out,
  output logic                     vsync_out
);

  localparam int PW    = 3 * COLOR_DEPTH;
  localparam int NPAL  = 1 << BPP;
  localparam int DLY   = MEM_LATENCY + 1;
  localparam int IMG_W = IMG_WIDTH << SCALE_SHIFT;   // image span on screen
  localparam int IMG_H = IMG_HEIGHT << SCALE_SHIFT;

  // Power-up palette contents; entries beyond the first four are black.
  function automatic logic [PW-1:0] pal_default(input int idx);
    logic [23:0] rgb24;
    case (idx)
      32'd0:   rgb24 = 24'hD9D9D9;
      32'd1:   rgb24 = 24'h000000;
      32'd2:   rgb24 = 24'h69923E;
      32'd3:   rgb24 = 24'hFFFFFF;
      default: rgb24 = 24'h000000;
    endcase
    return PW'(rgb24);
  endfunction

  // Stage A combinational terms
  logic signed [31:0] x_rel_d;
  logic signed [31:0] y_rel_d;
  logic [31:0]        ix_d;
  logic [31:0]        iy_d;
  logic               in_img_d;
  logic [ADDR_W-1:0]  mem_addr_d;

  // Pipeline registers
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DLY-1:0]     de_dl_q;
  logic [DLY-1:0]     img_dl_q;
  logic [DLY-1:0]     hs_dl_q;
  logic [DLY-1:0]     vs_dl_q;
  logic [PW-1:0]      rgb_d;
  logic [PW-1:0]      rgb_q;
  logic               de_q;
  logic               hs_q;
  logic               vs_q;

  // Palette storage
  logic [PW-1:0]      pal_q [NPAL];
  logic               pal_wr_s;

  // Stage A: image window test and linear bitmap address.
  always_comb begin
    x_rel_d  = $signed({22'd0, hcount}) - X0;
    y_rel_d  = $signed({22'd0, vcount}) - Y0;
    // Signed relative coordinates make "left of / above the image" negative.
    // Coordinates are also clipped to the active screen area.
    in_img_d = (x_rel_d >= 32'sd0) && (x_rel_d < IMG_W) &&
               (y_rel_d >= 32'sd0) && (y_rel_d < IMG_H) &&
               ($signed({22'd0, hcount}) < SCREEN_WIDTH) &&
               ($signed({22'd0, vcount}) < SCREEN_HEIGHT);
    ix_d     = 32'(x_rel_d) >> SCALE_SHIFT;
    iy_d     = 32'(y_rel_d) >> SCALE_SHIFT;
    if (in_img_d && de_in) begin
      mem_addr_d = ADDR_W'(iy_d * 32'(IMG_WIDTH) + ix_d);
    end else begin
      mem_addr_d = {ADDR_W{1'b0}};
    end
  end

  // Stage C: select blank, border or palette colour for the aligned pixel.
  always_comb begin
    rgb_d = {PW{1'b0}};
    if (!de_dl_q[DLY-1]) begin
      rgb_d = {PW{1'b0}};
    end else if (!img_dl_q[DLY-1]) begin
      rgb_d = PW'(BORDER_COLOR);
    end else begin
      rgb_d = pal_q[mem_rdata];
    end
  end

  // Writes are held off during the active area when SAFE_WRITE is set.
  assign pal_ready = (SAFE_WRITE != 0) ? ~de_in : 1'b1;
  assign pal_wr_s  = pal_we & pal_ready;

  // Address register, timing delay line and output registers.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      mem_addr_q <= {ADDR_W{1'b0}};
      de_dl_q    <= {DLY{1'b0}};
      img_dl_q   <= {DLY{1'b0}};
      hs_dl_q    <= {DLY{1'b0}};
      vs_dl_q    <= {DLY{1'b0}};
      rgb_q      <= {PW{1'b0}};
      de_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      // Stage 0 is captured on the same edge as mem_addr. The last stage
      // lines up with mem_rdata.
      de_dl_q    <= {de_dl_q[DLY-2:0], de_in};
      img_dl_q   <= {img_dl_q[DLY-2:0], in_img_d};
      hs_dl_q    <= {hs_dl_q[DLY-2:0], hsync_in};
      vs_dl_q    <= {vs_dl_q[DLY-2:0], vsync_in};
      rgb_q      <= rgb_d;
      de_q       <= de_dl_q[DLY-1];
      hs_q       <= hs_dl_q[DLY-1];
      vs_q       <= vs_dl_q[DLY-1];
    end
  end

  // Palette: defaults on reset, one accepted write per edge.
  // A lookup on the write edge still sees the old entry.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else begin
      if (pal_wr_s) begin
        pal_q[pal_waddr] <= pal_wdata;
      end else begin
        pal_q[pal_waddr] <= pal_q[pal_waddr];
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign vga_r     = rgb_q[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
  assign vga_g     = rgb_q[2*COLOR_DEPTH-1:COLOR_DEPTH];
  assign vga_b     = rgb_q[COLOR_DEPTH-1:0];
  assign de_out    = de_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule
